hash_req_arbiter: RTL and testbench

HASH_REQ_ARBITER -- requirements
Module: hash_req_arbiter

---
 rtl/hash_req_arbiter_if.sv | 39 +++
 rtl/hash_req_arbiter.sv | 120 ++++++++++++
 tb/tb_hash_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_req_arbiter_if.sv
// Signal bundle joining two hash requesters, the shared hash core and the response consumer.
// The master modport is the arbiter's view; the slave modport is its environment's view.
interface hash_req_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              core_start;
  logic [DATA_W-1:0] core_data;
  logic              core_done;
  logic [DATA_W-1:0] core_digest;
  logic [2:0]        core_status;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_digest;
  logic              rsp_ok;
  logic              busy;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  core_done, core_digest, core_status, rsp_ready,
    output req0_ready, req1_ready, core_start, core_data,
    output rsp_valid, rsp_id, rsp_digest, rsp_ok, busy
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data,
    output core_done, core_digest, core_status, rsp_ready,
    input  req0_ready, req1_ready, core_start, core_data,
    input  rsp_valid, rsp_id, rsp_digest, rsp_ok, busy
  );
endinterface

// File: rtl/hash_req_arbiter.sv
// Round-robin arbiter sharing one hash core between two requesters, one transaction at a time.
// Optional WAIT watchdog enabled by defining HASH_ARB_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
module hash_req_arbiter #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  hash_req_arbiter_if.master   bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              prio;
  logic [DATA_W-1:0] core_data;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_digest;
  logic              rsp_ok;

  logic              any_req;
  logic              grant;
  logic              grant_id;
  logic              done_hit;
  logic              timeout_hit;

  function automatic logic status_ok(input logic [2:0] status);
    return status == 3'd1;
  endfunction

  function automatic logic [DATA_W-1:0] gate_digest(input logic [DATA_W-1:0] digest,
                                                    input logic              ok);
    return ok ? digest : '0;
  endfunction

  // Grant decision: pointer breaks ties, a lone requester always wins.
  // Grants are suppressed while reset is asserted so no ready strobe leaks out.
  always_comb begin
    any_req  = bus.req0_valid | bus.req1_valid;
    grant_id = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    grant    = (state == IDLE) && any_req && !reset;
    done_hit = (state == WAIT) && bus.core_done;
  end

`ifdef HASH_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Cleared during LAUNCH so it reads 0 on the first WAIT cycle; WAIT lasts at most TIMEOUT_CYC cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT) && !bus.core_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture at grant, result capture at completion or watchdog expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio       <= 1'b0;
      core_data  <= '0;
      rsp_id     <= 1'b0;
      rsp_digest <= '0;
      rsp_ok     <= 1'b0;
    end else begin
      if (grant) begin
        core_data <= grant_id ? bus.req1_data : bus.req0_data;
        rsp_id    <= grant_id;
        prio      <= ~grant_id;
      end
      if (done_hit) begin
        rsp_ok     <= status_ok(bus.core_status);
        rsp_digest <= gate_digest(bus.core_digest, status_ok(bus.core_status));
      end else if (timeout_hit) begin
        rsp_ok     <= 1'b0;
        rsp_digest <= '0;
      end
    end
  end

  assign bus.req0_ready = grant && !grant_id;
  assign bus.req1_ready = grant && grant_id;
  assign bus.core_start = (state == LAUNCH);
  assign bus.core_data  = core_data;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_digest = rsp_digest;
  assign bus.rsp_ok     = rsp_ok;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Directed bench for hash_req_arbiter: lone request, contention, fault, backpressure,
// reset mid-transaction and, with HASH_ARB_TIMEOUT_EN, the watchdog.
module tb_hash_req_arbiter;
  localparam int DATA_W = 32;
  localparam int TO_CYC = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hash_req_arbiter_if #(.DATA_W(DATA_W)) bus ();

  hash_req_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req0_valid  = 1'b0;
    bus.req0_data   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_data   = '0;
    bus.core_done   = 1'b0;
    bus.core_digest = '0;
    bus.core_status = 3'd0;
    bus.rsp_ready   = 1'b1;

    // Reset state, including no grant while reset is held.
    tick();
    tick();
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_data", bus.core_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_digest", bus.rsp_digest, 0);
    chk("rst_rsp_ok", bus.rsp_ok, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Lone request from requester 0.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h1234;
    #1;
    chk("lone_req0_ready", bus.req0_ready, 1);
    chk("lone_req1_ready", bus.req1_ready, 0);
    chk("lone_idle_start", bus.core_start, 0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("lone_launch_start", bus.core_start, 1);
    chk("lone_launch_ready", bus.req0_ready, 0);
    chk("lone_core_data", bus.core_data, 32'h1234);
    chk("lone_busy", bus.busy, 1);
    tick();
    chk("lone_wait_start", bus.core_start, 0);
    chk("lone_wait_rsp_valid", bus.rsp_valid, 0);
    bus.core_done   = 1'b1;
    bus.core_digest = 32'hABCD;
    bus.core_status = 3'd1;
    tick();
    bus.core_done = 1'b0;
    chk("lone_rsp_valid", bus.rsp_valid, 1);
    chk("lone_rsp_id", bus.rsp_id, 0);
    chk("lone_rsp_digest", bus.rsp_digest, 32'hABCD);
    chk("lone_rsp_ok", bus.rsp_ok, 1);
    tick();
    chk("lone_rsp_one_cycle", bus.rsp_valid, 0);
    chk("lone_idle_busy", bus.busy, 0);

    // Contention from a fresh pointer: grants alternate 0,1,0,1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hA0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = i[0];
      #1;
      chk("cont_req0_ready", bus.req0_ready, {31'd0, !exp_id});
      chk("cont_req1_ready", bus.req1_ready, {31'd0, exp_id});
      tick();
      chk("cont_core_data", bus.core_data, exp_id ? 32'hB1 : 32'hA0);
      chk("cont_launch_readies", {bus.req0_ready, bus.req1_ready}, 0);
      tick();
      bus.core_done   = 1'b1;
      bus.core_digest = 32'h100 + i;
      bus.core_status = 3'd1;
      tick();
      bus.core_done = 1'b0;
      chk("cont_rsp_valid", bus.rsp_valid, 1);
      chk("cont_rsp_id", bus.rsp_id, {31'd0, exp_id});
      chk("cont_rsp_digest", bus.rsp_digest, 32'h100 + i);
      chk("cont_resp_readies", {bus.req0_ready, bus.req1_ready}, 0);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Fault status, and a core_done during LAUNCH is ignored.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h55;
    #1;
    chk("fault_lone_req1", bus.req1_ready, 1);
    tick();
    bus.req1_valid  = 1'b0;
    bus.core_done   = 1'b1;
    bus.core_digest = 32'hDEAD;
    bus.core_status = 3'd1;
    tick();
    bus.core_done = 1'b0;
    chk("stray_done_wait_busy", bus.busy, 1);
    chk("stray_done_no_rsp", bus.rsp_valid, 0);
    tick();
    chk("stray_done_still_wait", bus.rsp_valid, 0);
    bus.core_done   = 1'b1;
    bus.core_digest = 32'hBEEF;
    bus.core_status = 3'd5;
    tick();
    bus.core_done = 1'b0;
    chk("fault_rsp_valid", bus.rsp_valid, 1);
    chk("fault_rsp_ok", bus.rsp_ok, 0);
    chk("fault_rsp_digest", bus.rsp_digest, 0);
    chk("fault_rsp_id", bus.rsp_id, 1);
    tick();

    // Backpressure: response held while rsp_ready is low, no grant meanwhile.
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h4444;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.core_done   = 1'b1;
    bus.core_digest = 32'h7777;
    bus.core_status = 3'd1;
    tick();
    bus.core_done  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_id", bus.rsp_id, 0);
      chk("bp_rsp_digest", bus.rsp_digest, 32'h7777);
      chk("bp_rsp_ok", bus.rsp_ok, 1);
      chk("bp_no_grant", {bus.req0_ready, bus.req1_ready}, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_idle_rsp_valid", bus.rsp_valid, 0);
    chk("bp_rr_req1_ready", bus.req1_ready, 1);
    chk("bp_rr_req0_ready", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Reset in WAIT drops the request and restores the pointer to 0.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h9;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("rstw_in_wait", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_busy", bus.busy, 0);
    chk("rstw_rsp_valid", bus.rsp_valid, 0);
    bus.core_done   = 1'b1;
    bus.core_digest = 32'h1111;
    bus.core_status = 3'd1;
    tick();
    bus.core_done = 1'b0;
    chk("rstw_no_rsp", bus.rsp_valid, 0);
    chk("rstw_still_idle", bus.busy, 0);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h21;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h31;
    #1;
    chk("rstw_grant0_ready", bus.req0_ready, 1);
    chk("rstw_grant1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rstw_core_data", bus.core_data, 32'h21);
    tick();

`ifdef HASH_ARB_TIMEOUT_EN
    // Watchdog expiry after TO_CYC WAIT cycles.
    for (int k = 1; k <= TO_CYC; k++) begin
      chk("to_wait_rsp_valid", bus.rsp_valid, 0);
      chk("to_wait_busy", bus.busy, 1);
      tick();
    end
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_ok", bus.rsp_ok, 0);
    chk("to_rsp_digest", bus.rsp_digest, 0);
    tick();
    // core_done on the expiry cycle wins over the timeout.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h77;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    for (int k = 1; k < TO_CYC; k++) tick();
    bus.core_done   = 1'b1;
    bus.core_digest = 32'h8888;
    bus.core_status = 3'd1;
    tick();
    bus.core_done = 1'b0;
    chk("to_race_rsp_valid", bus.rsp_valid, 1);
    chk("to_race_rsp_ok", bus.rsp_ok, 1);
    chk("to_race_rsp_digest", bus.rsp_digest, 32'h8888);
    tick();
`else
    // Without the watchdog, WAIT persists until core_done.
    for (int k = 0; k < 3 * TO_CYC; k++) tick();
    chk("nowd_still_wait", bus.busy, 1);
    chk("nowd_no_rsp", bus.rsp_valid, 0);
    bus.core_done   = 1'b1;
    bus.core_digest = 32'h6666;
    bus.core_status = 3'd1;
    tick();
    bus.core_done = 1'b0;
    chk("nowd_rsp_valid", bus.rsp_valid, 1);
    chk("nowd_rsp_digest", bus.rsp_digest, 32'h6666);
    tick();
`endif
    chk("end_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
